// File: rtl/fc_bias_fetcher.sv
// Streams one FC layer's biases from the bias ROM to the accumulator over valid/ready.
// Optional FC_BIAS_CHECKSUM_EN adds an XOR checksum of the streamed words.
module fc_bias_fetcher #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 74,
  parameter int FC1_SIZE = 64,
  parameter int FC2_SIZE = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     layer_sel,
  output logic                     busy,
  output logic                     done,
  output logic                     rom_read_enable,
  output logic                     rom_fc_layer_select,
  output logic [$clog2(DEPTH)-1:0] rom_addr,
  input  logic [WIDTH-1:0]         rom_bias_in,
  output logic                     bias_valid,
  input  logic                     bias_ready,
  output logic [WIDTH-1:0]         bias_data,
  output logic [$clog2(DEPTH)-1:0] bias_idx,
`ifdef FC_BIAS_CHECKSUM_EN
  output logic [WIDTH-1:0]         bias_checksum,
`endif
  output logic                     bias_last
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   n_q, issue_cnt, out_cnt, addr_q;
  logic            inflight, done_q;
  logic [WIDTH-1:0] mem_data [2];
  logic [AW-1:0]   mem_idx [2];
  logic            rd_ptr, wr_ptr;
  logic [1:0]      fifo_count;
  logic            accept, push, pop, issue, credit, last_pop;

  assign accept     = (state == IDLE) && start;
  assign push       = inflight;
  assign bias_valid = (fifo_count != 2'd0);
  assign pop        = bias_valid && bias_ready;
  // A read may issue only if its word is guaranteed a FIFO slot when it lands.
  assign credit     = ({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
  assign issue      = (state == FETCH) && (issue_cnt < n_q) && credit;
  assign last_pop   = (state == DRAIN) && pop && (out_cnt == n_q - AW'(1));

  assign busy            = (state != IDLE);
  assign done            = done_q;
  assign rom_read_enable = issue;
  assign rom_addr        = issue ? issue_cnt : addr_q;
  assign bias_data       = mem_data[rd_ptr];
  assign bias_idx        = mem_idx[rd_ptr];
  assign bias_last       = bias_valid && (bias_idx == n_q - AW'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (issue_cnt == n_q) state_nxt = DRAIN;
      DRAIN:   if (last_pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      done_q              <= 1'b0;
      rom_fc_layer_select <= 1'b0;
      n_q                 <= '0;
      issue_cnt           <= '0;
      out_cnt             <= '0;
      addr_q              <= '0;
      inflight            <= 1'b0;
    end else begin
      state    <= state_nxt;
      done_q   <= last_pop;
      inflight <= issue;
      if (issue) addr_q <= issue_cnt;
      if (accept) begin
        rom_fc_layer_select <= layer_sel;
        n_q                 <= layer_sel ? AW'(FC2_SIZE) : AW'(FC1_SIZE);
        issue_cnt           <= '0;
        out_cnt             <= '0;
      end else begin
        if (issue) issue_cnt <= issue_cnt + AW'(1);
        if (pop)   out_cnt   <= out_cnt + AW'(1);
      end
    end
  end

  // Two-entry skid FIFO absorbing the ROM read latency; index travels with data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_data[0] <= '0;
      mem_data[1] <= '0;
      mem_idx[0]  <= '0;
      mem_idx[1]  <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= rom_bias_in;
        mem_idx[wr_ptr]  <= addr_q;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

  assert property (@(posedge clk) disable iff (reset) !(push && !pop && fifo_count == 2'd2));

`ifdef FC_BIAS_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       bias_checksum <= '0;
    else if (accept) bias_checksum <= '0;
    else if (pop)    bias_checksum <= bias_checksum ^ bias_data;
  end
`endif

endmodule

// File: tb/tb_fc_bias_fetcher.sv
// Self-checking bench for fc_bias_fetcher: ROM model plus a layer-level reference of
// the expected bias stream, with randomized ROM contents and consumer backpressure.
module tb_fc_bias_fetcher;

  localparam int WIDTH = 32;
  localparam int DEPTH = 74;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             layer_sel;
  logic             busy;
  logic             done;
  logic             rom_read_enable;
  logic             rom_fc_layer_select;
  logic [AW-1:0]    rom_addr;
  logic [WIDTH-1:0] rom_bias_in;
  logic             bias_valid;
  logic             bias_ready;
  logic [WIDTH-1:0] bias_data;
  logic [AW-1:0]    bias_idx;
  logic             bias_last;
`ifdef FC_BIAS_CHECKSUM_EN
  logic [WIDTH-1:0] bias_checksum;
`endif

  logic [WIDTH-1:0] rom [DEPTH];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fc_bias_fetcher dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .layer_sel           (layer_sel),
    .busy                (busy),
    .done                (done),
    .rom_read_enable     (rom_read_enable),
    .rom_fc_layer_select (rom_fc_layer_select),
    .rom_addr            (rom_addr),
    .rom_bias_in         (rom_bias_in),
    .bias_valid          (bias_valid),
    .bias_ready          (bias_ready),
    .bias_data           (bias_data),
    .bias_idx            (bias_idx),
`ifdef FC_BIAS_CHECKSUM_EN
    .bias_checksum       (bias_checksum),
`endif
    .bias_last           (bias_last)
  );

  // ROM with one cycle of read latency; FC2 words live above the FC1 block.
  always @(posedge clk) begin
    if (rom_read_enable)
      rom_bias_in <= rom[rom_fc_layer_select ? 64 + int'(rom_addr) : int'(rom_addr)];
  end

  task automatic load_rom(input int kind);
    for (int i = 0; i < DEPTH; i++) begin
      if (kind == 0)      rom[i] = 32'h100 + i;
      else if (kind == 1) rom[i] = $urandom;
      else                rom[i] = (i >= 64) ? (32'h1 << (i - 64)) : 32'hDEAD_0000 + i;
    end
  endtask

  // mode 0: ready always high; 1: ready pattern 1,0,0,1; 2: random ready.
  // Returns in the done cycle (just after the falling edge sample).
  task automatic run_layer(input logic sel, input int mode, input int restart_at,
                           output logic [WIDTH-1:0] xr);
    int n, off, cyc, issued, beats, outstanding, first_valid, last_pop_cyc;
    logic pop, prev_stall, saw_done;
    logic [WIDTH-1:0] pd;
    logic [AW-1:0] pi;
    n = sel ? 10 : 64;
    off = sel ? 64 : 0;
    cyc = 0; issued = 0; beats = 0; outstanding = 0;
    first_valid = -1; last_pop_cyc = -1; prev_stall = 1'b0; saw_done = 1'b0;
    pd = '0; pi = '0; xr = '0;
    @(negedge clk);
    start = 1'b1; layer_sel = sel; bias_ready = 1'b1;
    while (!saw_done) begin
      @(negedge clk);
      cyc++;
      start = (cyc == restart_at);
      if (start) layer_sel = ~sel;
      case (mode)
        0:       bias_ready = 1'b1;
        1:       bias_ready = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
        default: bias_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      pop = bias_valid && bias_ready;
      if (cyc == 1) begin
        checks++;
        if (rom_read_enable !== 1'b1 || rom_addr !== '0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL first_read: re=%b addr=%0d busy=%b required re=1 addr=0 busy=1",
                   rom_read_enable, rom_addr, busy);
        end
      end
      if (rom_read_enable) begin
        checks++;
        if (outstanding - int'(pop) >= 2 || int'(rom_addr) != issued ||
            rom_fc_layer_select !== sel || issued >= n) begin
          errors++;
          $display("FAIL read_issue: addr=%0d sel=%b outstanding=%0d required addr=%0d sel=%b outstanding<2",
                   rom_addr, rom_fc_layer_select, outstanding - int'(pop), issued, sel);
        end
        issued++;
      end
      if (prev_stall) begin
        checks++;
        if (bias_valid !== 1'b1 || bias_data !== pd || bias_idx !== pi) begin
          errors++;
          $display("FAIL stall_stable: valid=%b data=%h idx=%0d required valid=1 data=%h idx=%0d",
                   bias_valid, bias_data, bias_idx, pd, pi);
        end
      end
      if (bias_valid) begin
        if (first_valid < 0) first_valid = cyc;
        checks++;
        if (int'(bias_idx) != beats || bias_data !== rom[off + beats] ||
            bias_last !== (beats == n - 1)) begin
          errors++;
          $display("FAIL beat: idx=%0d data=%h last=%b required idx=%0d data=%h last=%b",
                   bias_idx, bias_data, bias_last, beats, rom[off + beats], beats == n - 1);
        end
      end else if (mode == 0 && first_valid >= 0 && beats < n) begin
        checks++;
        errors++;
        $display("FAIL gap: valid=0 at cycle %0d required valid=1 (beat %0d)", cyc, beats);
      end
      prev_stall = bias_valid && !bias_ready;
      pd = bias_data;
      pi = bias_idx;
      if (pop) begin
        xr = xr ^ rom[off + beats];
        beats++;
        last_pop_cyc = cyc;
      end
      if (done) begin
        saw_done = 1'b1;
        checks++;
        if (beats != n || cyc != last_pop_cyc + 1 || busy !== 1'b0 || bias_valid !== 1'b0) begin
          errors++;
          $display("FAIL done: cycle=%0d beats=%0d busy=%b required cycle=%0d beats=%0d busy=0",
                   cyc, beats, busy, last_pop_cyc + 1, n);
        end
        if (mode == 0) begin
          checks++;
          if (first_valid != 3 || cyc != n + 3) begin
            errors++;
            $display("FAIL latency: first_valid=%0d done=%0d required first_valid=3 done=%0d",
                     first_valid, cyc, n + 3);
          end
        end
`ifdef FC_BIAS_CHECKSUM_EN
        checks++;
        if (bias_checksum !== xr) begin
          errors++;
          $display("FAIL checksum: got %h required %h", bias_checksum, xr);
        end
`endif
      end
      outstanding = outstanding + int'(rom_read_enable) - int'(pop);
      if (cyc > 2000 && !saw_done) begin
        checks++;
        errors++;
        $display("FAIL timeout: no done after %0d cycles (beats=%0d of %0d)", cyc, beats, n);
        saw_done = 1'b1;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rom_read_enable !== 1'b0 || rom_addr !== '0 ||
        rom_fc_layer_select !== 1'b0 || bias_valid !== 1'b0 || bias_last !== 1'b0 ||
        bias_idx !== '0 || bias_data !== '0) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b re=%b addr=%0d sel=%b valid=%b last=%b idx=%0d data=%h required all zero",
               tag, busy, done, rom_read_enable, rom_addr, rom_fc_layer_select, bias_valid,
               bias_last, bias_idx, bias_data);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; layer_sel = 1'b0; bias_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values("reset_values");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_fc2_basic();
    logic [WIDTH-1:0] xr;
    load_rom(0);
    run_layer(1'b1, 0, -1, xr);
  endtask

  task automatic test_fc1_stream();
    logic [WIDTH-1:0] xr;
    load_rom(1);
    run_layer(1'b0, 0, -1, xr);
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] xr;
    load_rom(1);
    run_layer(1'b1, 1, -1, xr);
    load_rom(1);
    run_layer(1'b0, 2, -1, xr);
  endtask

  task automatic test_restart();
    logic [WIDTH-1:0] xr;
    int waited;
    load_rom(1);
    run_layer(1'b1, 0, 5, xr);
    start = 1'b1; layer_sel = 1'b0;
    @(negedge clk);
    start = 1'b0; bias_ready = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || rom_read_enable !== 1'b1 || rom_addr !== '0 || rom_fc_layer_select !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done: busy=%b re=%b addr=%0d sel=%b required busy=1 re=1 addr=0 sel=0",
               busy, rom_read_enable, rom_addr, rom_fc_layer_select);
    end
    waited = 0;
    while (!done && waited < 300) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL restart_done: done=%b after %0d cycles required done=1", done, waited);
    end
  endtask

  task automatic test_reset_midway();
    logic [WIDTH-1:0] xr;
    int stray;
    load_rom(1);
    @(negedge clk);
    start = 1'b1; layer_sel = 1'b0; bias_ready = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_values("reset_midway");
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (bias_valid || busy || rom_read_enable) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL post_reset_quiet: active cycles=%0d required 0", stray);
    end
    run_layer(1'b1, 2, -1, xr);
  endtask

`ifdef FC_BIAS_CHECKSUM_EN
  task automatic test_checksum();
    logic [WIDTH-1:0] xr;
    load_rom(2);
    run_layer(1'b1, 2, -1, xr);
    checks++;
    if (bias_checksum !== 32'h3FF) begin
      errors++;
      $display("FAIL checksum_fc2: got %h required 000003ff", bias_checksum);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fc2_basic();
    test_fc1_stream();
    test_backpressure();
    test_restart();
    test_reset_midway();
`ifdef FC_BIAS_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fc_bias_fetcher.md
Name: fc_bias_fetcher

Overview:
Read-side initiator for the FC bias ROM. On a start pulse it walks every neuron bias of the selected FC layer (FC1 or FC2) by driving the ROM's read_enable, fc_layer_select and addr. It absorbs the ROM's 1-cycle read latency and streams the biases to the FC accumulator over a valid/ready interface, with full backpressure and no lost or duplicated words.

Parameters:
WIDTH, 32, bias word width (matches ROM)
DEPTH, 74, ROM depth; address width is $clog2(DEPTH)
FC1_SIZE, 64, FC1 neuron count
FC2_SIZE, 10, FC2 neuron count

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  1-cycle request to fetch one layer; ignored while busy
layer_sel  in  1  0 = FC1, 1 = FC2; sampled with start
busy  out  1  fetch in progress
done  out  1  1-cycle pulse after the final bias handshake
rom_read_enable  out  1  to ROM read_enable
rom_fc_layer_select  out  1  to ROM fc_layer_select; holds latched layer_sel
rom_addr  out  $clog2(DEPTH)  to ROM addr; in-layer index
rom_bias_in  in  WIDTH  from ROM bias_out; valid the cycle after rom_read_enable
bias_valid  out  1  bias_data valid
bias_ready  in  1  consumer accepts
bias_data  out  WIDTH  bias word
bias_idx  out  $clog2(DEPTH)  neuron index of bias_data
bias_last  out  1  high with the final bias of the layer

Behaviour:
- Reset clears all state and the FIFO. Reset values: busy=0, done=0, rom_read_enable=0, rom_addr=0, rom_fc_layer_select=0, bias_valid=0, bias_last=0, bias_idx=0, bias_data=0.
- Reset asserted mid-operation discards any in-flight ROM read; its data is never pushed.
- FSM states:
  - IDLE: start → FETCH. Latch layer_sel. Set N = FC1_SIZE or FC2_SIZE. Clear issue_cnt and out_cnt.
  - FETCH: issue reads. Move to DRAIN when issue_cnt == N.
  - DRAIN: wait until out_cnt == N, then go to IDLE.
- busy is high in FETCH and DRAIN. start while busy has no effect.
- Read issue: rom_read_enable is high when state == FETCH, issue_cnt < N, and (fifo_count + inflight − pop) < 2.
  - rom_addr = issue_cnt while rom_read_enable is high. issue_cnt increments on each issued read.
  - rom_addr holds its value when no read is issued.
- inflight is a registered copy of rom_read_enable. When inflight is high, rom_bias_in is pushed into a 2-entry FIFO together with its index.
- Credit rule: the FIFO never overflows. An overflow is a design error, flagged by a simulation assertion.
- Output side:
  - bias_valid = FIFO non-empty. Pop on bias_valid && bias_ready.
  - bias_data and bias_idx are stable while valid && !ready.
  - bias_last = (bias_idx == N−1) && bias_valid.
- out_cnt increments on each pop.
- done pulses for one cycle in the cycle after the last pop. busy falls in that same cycle. A start may be accepted in the done cycle.
- Latency:
  - start at cycle 0 → first rom_read_enable at cycle 1 (addr 0).
  - ROM data at cycle 2 → bias_valid at cycle 3.
  - With bias_ready held high, throughput is 1 bias/cycle.
- Address width: all counters are $clog2(DEPTH) bits. No layer offset is applied here; the ROM applies the FC1_SIZE offset itself.

Optional Feature:
Macro FC_BIAS_CHECKSUM_EN.
- Defined: adds output port bias_checksum [WIDTH-1:0].
  - Cleared on reset and on start acceptance.
  - XOR-accumulates bias_data on every pop.
  - Final value is valid when done is high.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Reset, then start with layer_sel=1 and bias_ready=1; ROM loaded with rom[i]=i+0x100.
   → rom_addr walks 0..9 with rom_fc_layer_select=1.
   → bias_valid high in cycles 3..12; bias_data equals the ROM word for each index 0..9 (ROM adds offset 64).
   → bias_last in cycle 12; done in cycle 13.
2. layer_sel=0 with bias_ready=1.
   → 64 beats, bias_idx 0..63 in order, no gaps after the first beat.
   → bias_last only on idx 63; done exactly once.
3. layer_sel=1 with bias_ready toggling 1,0,0,1 repeating.
   → no word lost or duplicated; data stable while stalled.
   → rom_read_enable never issued when fifo_count + inflight = 2.
4. start pulsed again in cycle 5 of a running FC2 fetch.
   → ignored: exactly 10 beats and one done.
   → a start in the done cycle is accepted and begins a new layer.
5. reset asserted at cycle 6 of an FC1 fetch while a read is in flight.
   → all outputs go to reset values immediately.
   → no bias_valid after release until a new start.
6. With FC_BIAS_CHECKSUM_EN defined, FC2 fetch over rom[64+i]=1<<i.
   → bias_checksum = 0x3FF when done is high.
